nibble_fifo: RTL
================

NIBBLE_FIFO -- requirements
Module: nibble_fifo

Interface
REQ-001 Parameter WIDTH, default 4: data width in bits; matches the 4-bit enabled register stage this FIFO feeds.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low; asserts immediately, releases synchronously to clk.
REQ-005 Port wr_en  input  1: write request, sampled at posedge clk.
REQ-006 Port wr_data  input  WIDTH: write data, sampled when wr_en=1.
REQ-007 Port rd_en  input  1: read request, sampled at posedge clk.
REQ-008 Port rd_data  output  WIDTH: registered read data; connects to the downstream register's in.
REQ-009 Port rd_valid  output  1: one-cycle pulse marking rd_data as new; connects to the downstream register's en.
REQ-010 Port full  output  1: high when count == DEPTH.
REQ-011 Port empty  output  1: high when count == 0.
REQ-012 Port count  output  clog2(DEPTH)+1: current occupancy, range 0..DEPTH.
REQ-013 Port overflow  output  1: sticky flag for a dropped write.
REQ-014 Port underflow  output  1: sticky flag for a rejected read.

Function
REQ-015 Storage: DEPTH x WIDTH register array, plus a write pointer and a read pointer, each clog2(DEPTH) bits wide.
REQ-016 Pointer wrap: pointers increment modulo DEPTH (DEPTH-1 -> 0) with no extra logic.
REQ-017 Write accept: a write is accepted iff wr_en=1 and full=0 at the clock edge; it stores wr_data at wr_ptr and increments wr_ptr.
REQ-018 Read accept: a read is accepted iff rd_en=1 and empty=0 at the clock edge; it loads mem[rd_ptr] into rd_data and increments rd_ptr.
REQ-019 Read latency: rd_data is updated and rd_valid=1 on the edge that accepts the read (data visible one cycle after rd_en is presented).
REQ-020 rd_valid: 0 on every cycle without an accepted read; back-to-back accepted reads hold rd_valid=1 continuously.
REQ-021 rd_data hold: rd_data holds its last value when no read is accepted.
REQ-022 Count update: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-023 Full/empty: full and empty are derived combinationally from count and are never both 1.
REQ-024 Simultaneous read and write when full: the read is accepted and the write is rejected (full sampled pre-edge); count becomes DEPTH-1; overflow is set.
REQ-025 Simultaneous read and write when empty: the write is accepted and the read is rejected; count becomes 1; underflow is set; rd_valid=0.
REQ-026 Simultaneous read and write otherwise: both are accepted, count is unchanged, and both pointers advance.
REQ-027 Overflow: set on any wr_en=1 while full=1; it stays set until reset, and the FIFO contents are unaffected.
REQ-028 Underflow: set on any rd_en=1 while empty=1; it stays set until reset, and rd_data is unaffected.
REQ-029 Order: data is read out in write order (FIFO); no entry is duplicated or skipped across pointer wrap.

Reset
REQ-030 When rst=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, all asynchronously.
REQ-031 Memory array contents are not reset and are unobservable while empty.
REQ-032 Reset asserted mid-operation discards all stored entries; the first read after release requires a new write.
REQ-033 No write or read is accepted on the edge at which rst is low.

Verification
REQ-034 Reset scenario: hold rst=0 for 2 cycles with wr_en=1 and wr_data=4'hF -> count=0, empty=1, rd_valid=0, rd_data=0 throughout.
REQ-035 Fill/drain scenario: write 4'h3, 4'h7, 4'hA, 4'h1 -> full=1, count=4; then 4 reads -> rd_data 3,7,A,1 with rd_valid=1 for 4 consecutive cycles; then empty=1.
REQ-036 Overflow scenario: when full, write 4'hE -> overflow=1, count stays 4; drain -> 3,7,A,1 (4'hE is never output).
REQ-037 Underflow scenario: when empty, assert rd_en and wr_en=1 with wr_data=4'h5 -> underflow=1, rd_valid=0, count=1; next read -> rd_data=4'h5.
REQ-038 Wrap scenario: perform 10 single write-then-read pairs with data 0..9 -> each read returns the matching value; pointers wrap twice; count ends 0.
REQ-039 Mid-operation reset scenario: with count=3, pulse rst low between clock edges -> outputs clear immediately; after release, rd_en gives underflow=1 and no rd_valid.

Source files
------------

// File: rtl/nibble_fifo.sv
// nibble_fifo: small synchronous FIFO with registered read data.
// rd_data/rd_valid feed a downstream enabled register directly.
module nibble_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PINC = AW'(1);
  localparam logic [CW-1:0] CINC = CW'(1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full   = (count == CMAX);
  assign empty  = (count == '0);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage is not reset; gating on rst keeps writes out while held.
  always_ff @(posedge clk) begin
    if (wr_acc && rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PINC;
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PINC;
        rd_data <= mem[rd_ptr];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CINC;
        2'b01:   count <= count - CINC;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
